qcldpc_info_blk_packer: RTL and testbench
=========================================

Name: qcldpc_info_blk_packer

Overview:
- Input stage directly upstream of QCLDPCController.
- Accepts a narrow information-bit stream over a valid/ready handshake and packs it into Z-bit information blocks, zero-extended to HIGHEST_SUPPORTED_Z_VAL.
- Presents LEVEL_OF_PARALLELIZATION blocks per beat on a MaxZ*PLvl bus and frames exactly NUM_INFO_BLKS_PER_CODE_BLK blocks per codeword for the selected Z.

Parameters:
- NUM_OF_SUPPORTED_Z, 3, number of selectable expansion factors.
- HIGHEST_SUPPORTED_Z_VAL, 81, MaxZ; width of one block lane.
- Z_VALUE_ARRAY, {27,54,81}, Z per req_z one-hot bit (bit i selects entry i).
- NUM_INFO_BLKS_PER_CODE_BLK, 20, information blocks per codeword. Must be a multiple of PLvl.
- LEVEL_OF_PARALLELIZATION, 1, PLvl; blocks emitted per output beat.
- IN_W, 8, input word width. Must satisfy 1 <= IN_W <= min(Z_VALUE_ARRAY).

Ports:
- CLK, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, frame start pulse; sampled only in IDLE.
- req_z, in, NUM_OF_SUPPORTED_Z, one-hot Z select; sampled with start.
- s_data, in, IN_W, information bits, LSB is the earliest bit.
- s_valid, in, 1, s_data valid.
- s_ready, out, 1, packer accepts s_data.
- m_data, out, MaxZ*PLvl, packed blocks; slot j occupies [j*MaxZ +: MaxZ], and bits Z..MaxZ-1 of each slot are 0.
- m_valid, out, 1, m_data valid.
- m_ready, in, 1, consumer accepts m_data.
- blk_idx, out, $clog2(NUM_INFO_BLKS_PER_CODE_BLK), index of slot 0 block within the frame.
- frame_done, out, 1, one-cycle pulse when the last beat of a frame is accepted.
- cfg_err, out, 1, one-cycle pulse when start is seen with a non-one-hot req_z.

Behaviour:
- Reset values:
  - s_ready=0, m_valid=0, m_data=0, blk_idx=0, frame_done=0, cfg_err=0.
  - Internal accumulator, bit count, slot and block counters are 0; state=IDLE.
- Reset asserted mid-frame aborts immediately. No partial output is emitted after release.
- Transfers: input on s_valid&s_ready at the CLK edge; output on m_valid&m_ready at the CLK edge.
- States:
  - IDLE:
    - s_ready=0, m_valid=0.
    - start with $onehot(req_z): latch Z, clear counters, go to FILL.
    - start with non-one-hot req_z: cfg_err=1 next cycle, stay in IDLE.
  - FILL:
    - s_ready=1, m_valid=0.
    - Each accepted word is appended at accumulator bit position cnt.
    - If cnt+IN_W < Z: cnt += IN_W.
    - Else the block completes:
      - The low Z accumulated bits are written to slot p.
      - The residual cnt+IN_W-Z high bits become the new accumulator bits 0.., with cnt = residual.
      - p increments.
    - When slot PLvl-1 completes, go to HOLD.
    - When the frame's final block completes, the residual bits are discarded and cnt=0.
  - HOLD:
    - s_ready=0, m_valid=1; m_data and blk_idx are held stable.
    - On m_ready: blk_idx += PLvl and p=0.
    - If the frame's last beat is accepted: frame_done pulse, go to IDLE. Otherwise go to FILL.
- Latency: m_valid rises the cycle after the completing word is accepted. There is at least one bubble per beat.
- Words per frame = ceil(Z*NUM_INFO_BLKS_PER_CODE_BLK / IN_W).
- start outside IDLE is ignored. req_z changes mid-frame have no effect.
- s_valid low in FILL stalls without loss.
- m_ready may be held low indefinitely with no data change.

Optional Feature:
- QCLDPC_PACK_BITREV_EN defined: each s_data word is bit-reversed before accumulation, so the MSB is the earliest bit.
- Undefined: the LSB is the earliest bit, as above.
- Packing, framing and timing are otherwise identical.

Test Plan:
- Z=27, IN_W=8, PLvl=1, every word 0xFF:
  - 68 words are accepted.
  - 20 beats, each m_data[26:0]=27'h7FFFFFF with upper bits 0.
  - blk_idx 0..19; frame_done once, after beat 19. The last 4 bits of word 67 are dropped.
- Z=27, words 0x01,0x00,0x00,0x08:
  - Block0 = 27'h0000001.
  - Word3 bit3 appears as block1 bit0.
- Z=81 (req_z=3'b100): 203 words are accepted, 20 beats, frame_done. s_ready=0 after frame_done until the next start.
- Backpressure: m_ready held low 5 cycles at beat 3 → m_valid=1, s_ready=0, and m_data/blk_idx unchanged for all 5 cycles.
- req_z=3'b011 with start → cfg_err pulses 1 cycle, state stays IDLE, s_ready=0.
- rst_n low after 10 accepted words → all outputs return to reset values asynchronously. A fresh start yields block0 built from new words only.

Source files
------------

// File: rtl/qcldpc_info_blk_packer.sv
// Packs a narrow valid/ready bit stream into Z-bit information blocks, PLvl per output beat.
// Define QCLDPC_PACK_BITREV_EN to treat the MSB of each input word as the earliest bit.
module qcldpc_info_blk_packer #(
    parameter int NUM_OF_SUPPORTED_Z                        = 3,
    parameter int HIGHEST_SUPPORTED_Z_VAL                   = 81,
    parameter int Z_VALUE_ARRAY [NUM_OF_SUPPORTED_Z]        = '{27, 54, 81},
    parameter int NUM_INFO_BLKS_PER_CODE_BLK                = 20,
    parameter int LEVEL_OF_PARALLELIZATION                  = 1,
    parameter int IN_W                                      = 8,
    localparam int BLK_W = (NUM_INFO_BLKS_PER_CODE_BLK > 1) ? $clog2(NUM_INFO_BLKS_PER_CODE_BLK) : 1
) (
    input  logic                                                      CLK,
    input  logic                                                      rst_n,
    input  logic                                                      start,
    input  logic [NUM_OF_SUPPORTED_Z-1:0]                             req_z,
    input  logic [IN_W-1:0]                                           s_data,
    input  logic                                                      s_valid,
    output logic                                                      s_ready,
    output logic [HIGHEST_SUPPORTED_Z_VAL*LEVEL_OF_PARALLELIZATION-1:0] m_data,
    output logic                                                      m_valid,
    input  logic                                                      m_ready,
    output logic [BLK_W-1:0]                                          blk_idx,
    output logic                                                      frame_done,
    output logic                                                      cfg_err
);

    localparam int MAXZ  = HIGHEST_SUPPORTED_Z_VAL;
    localparam int PL    = LEVEL_OF_PARALLELIZATION;
    localparam int NBLK  = NUM_INFO_BLKS_PER_CODE_BLK;
    localparam int ACC_W = MAXZ + IN_W;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int ZW    = $clog2(MAXZ + 1);
    localparam int PW    = (PL > 1) ? $clog2(PL) : 1;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]        p_q, p_d;
    logic [ZW-1:0]        z_q, z_d;
    logic [BLK_W-1:0]     blk_idx_q, blk_idx_d;
    logic [MAXZ*PL-1:0]   m_data_q, m_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [IN_W-1:0]      word;
    logic [ACC_W-1:0]     acc_app;
    logic [ACC_W-1:0]     residual;
    logic [CNT_W-1:0]     cnt_sum;
    logic [MAXZ-1:0]      blk;
    logic [ZW-1:0]        z_sel;
    logic                 blk_done;
    logic                 last_blk;
    logic                 last_beat;

    always_comb begin
        word = s_data;
`ifdef QCLDPC_PACK_BITREV_EN
        for (int i = 0; i < IN_W; i++) word[i] = s_data[IN_W-1-i];
`endif
    end

    always_comb begin
        z_sel = '0;
        for (int i = 0; i < NUM_OF_SUPPORTED_Z; i++) begin
            if (req_z[i]) z_sel = ZW'(Z_VALUE_ARRAY[i]);
        end
    end

    // The incoming word lands at bit cnt; anything at or above Z spills into the next block.
    always_comb begin
        acc_app   = acc_q | (ACC_W'(word) << cnt_q);
        cnt_sum   = cnt_q + CNT_W'(IN_W);
        blk       = MAXZ'(acc_app) & ~({MAXZ{1'b1}} << z_q);
        residual  = acc_app >> z_q;
        blk_done  = (cnt_sum >= CNT_W'(z_q));
        last_blk  = ((int'(blk_idx_q) + int'(p_q)) == NBLK - 1);
        last_beat = ((int'(blk_idx_q) + PL) == NBLK);
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        p_d          = p_q;
        z_d          = z_q;
        blk_idx_d    = blk_idx_q;
        m_data_d     = m_data_q;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ($onehot(req_z)) begin
                        z_d       = z_sel;
                        acc_d     = '0;
                        cnt_d     = '0;
                        p_d       = '0;
                        blk_idx_d = '0;
                        state_d   = FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (s_valid) begin
                    if (!blk_done) begin
                        acc_d = acc_app;
                        cnt_d = cnt_sum;
                    end else begin
                        for (int j = 0; j < PL; j++) begin
                            if (p_q == PW'(j)) m_data_d[j*MAXZ +: MAXZ] = blk;
                        end
                        // Bits past the frame's final block belong to no block and are dropped.
                        if (last_blk) begin
                            acc_d = '0;
                            cnt_d = '0;
                        end else begin
                            acc_d = residual;
                            cnt_d = cnt_sum - CNT_W'(z_q);
                        end
                        if (p_q == PW'(PL - 1)) begin
                            p_d     = '0;
                            state_d = HOLD;
                        end else begin
                            p_d = p_q + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    blk_idx_d = blk_idx_q + BLK_W'(PL);
                    p_d       = '0;
                    if (last_beat) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            p_q          <= '0;
            z_q          <= '0;
            blk_idx_q    <= '0;
            m_data_q     <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            p_q          <= p_d;
            z_q          <= z_d;
            blk_idx_q    <= blk_idx_d;
            m_data_q     <= m_data_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign s_ready    = (state_q == FILL);
    assign m_valid    = (state_q == HOLD);
    assign m_data     = m_data_q;
    assign blk_idx    = blk_idx_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_qcldpc_info_blk_packer.sv
// Randomized bench for qcldpc_info_blk_packer: a bit-stream model predicts every beat and handshake.
module tb_qcldpc_info_blk_packer;

    localparam int MAXZ = 81;
    localparam int NB   = 20;
    localparam int PL   = 1;
    localparam int IW   = 8;
    int ZV [3] = '{27, 54, 81};

    logic              CLK = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        req_z;
    logic [IW-1:0]     s_data;
    logic              s_valid;
    logic              s_ready;
    logic [MAXZ*PL-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [4:0]        blk_idx;
    logic              frame_done;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    qcldpc_info_blk_packer dut (
        .CLK(CLK), .rst_n(rst_n), .start(start), .req_z(req_z),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .blk_idx(blk_idx), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the frame is one long bit stream; block k is stream bits [k*Z, k*Z+Z).
    bit mstream [0:2047];
    int mnbits, mbeats, mwords, mz, last_words;
    bit in_frame, armed, fd_exp, cerr_exp, exp_mv;
    logic [MAXZ-1:0] exp_blk;

    always @(negedge CLK) begin
        if (!rst_n) begin
            in_frame = 0; armed = 0; fd_exp = 0; cerr_exp = 0;
        end else begin
            chk("frame_done", frame_done, fd_exp);
            chk("cfg_err", cfg_err, cerr_exp);
            fd_exp = 0; cerr_exp = 0;
            if (armed) begin
                armed = 0; in_frame = 1; mnbits = 0; mbeats = 0; mwords = 0;
            end
            if (in_frame) begin
                exp_mv = (mnbits >= (mbeats + 1) * PL * mz);
                chk("m_valid", m_valid, exp_mv);
                chk("s_ready", s_ready, !exp_mv);
                if (m_valid && exp_mv) begin
                    for (int j = 0; j < PL; j++) begin
                        exp_blk = '0;
                        for (int b = 0; b < mz; b++) exp_blk[b] = mstream[(mbeats*PL + j)*mz + b];
                        chk("m_data_slot", m_data[j*MAXZ +: MAXZ], exp_blk);
                    end
                    chk("blk_idx", blk_idx, mbeats * PL);
                    if (m_ready) begin
                        mbeats++;
                        if (mbeats == NB / PL) begin
                            fd_exp = 1; in_frame = 0; last_words = mwords;
                            chk("words_per_frame", mwords, (mz * NB + IW - 1) / IW);
                        end
                    end
                end
                if (s_valid && s_ready) begin
                    for (int b = 0; b < IW; b++) begin
`ifdef QCLDPC_PACK_BITREV_EN
                        if (mnbits + b < 2048) mstream[mnbits + b] = s_data[IW-1-b];
`else
                        if (mnbits + b < 2048) mstream[mnbits + b] = s_data[b];
`endif
                    end
                    mnbits += IW; mwords++;
                end
            end else if (!armed) begin
                chk("idle_m_valid", m_valid, 1'b0);
                chk("idle_s_ready", s_ready, 1'b0);
                if (start) begin
                    if ($onehot(req_z)) begin
                        armed = 1;
                        for (int i = 0; i < 3; i++) if (req_z[i]) mz = ZV[i];
                    end else begin
                        cerr_exp = 1;
                    end
                end
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_blk_idx", blk_idx, '0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
    endtask

    function automatic logic [IW-1:0] gen_word(input int mode, input int idx);
        if (mode == 1) return 8'hFF;
        if (mode == 2) return (idx == 0) ? 8'h01 : (idx == 3) ? 8'h08 : 8'h00;
        return IW'($urandom);
    endfunction

    // mode 0 random / 1 all-ones / 2 directed; bp_beat holds m_ready low 5 cycles there.
    task automatic run_frame(input logic [2:0] rz, input int mode, input int bp_beat, input int abort_after);
        int widx = 0, beat = 0, hold = 0, cyc = 0;
        bit done = 0, acc_in, acc_out;
        logic [MAXZ*PL-1:0] snap_d;
        logic [4:0] snap_i;
        @(posedge CLK); #1;
        start = 1; req_z = rz; s_valid = 0; m_ready = 0;
        @(posedge CLK); #1;
        start = 0; req_z = 3'($urandom);
        s_data = gen_word(mode, 0); s_valid = 1'b1;
        m_ready = (beat == bp_beat) ? 1'b0 : 1'b1;
        while (!done) begin
            @(negedge CLK);
            acc_in = s_valid && s_ready;
            acc_out = m_valid && m_ready;
            if (m_valid && mode == 1) chk("ones_blk", m_data, 81'h7FFFFFF);
`ifndef QCLDPC_PACK_BITREV_EN
            if (m_valid && mode == 2 && beat < 2) chk("directed_blk", m_data, 81'h1);
`endif
            if (m_valid && beat == bp_beat && !m_ready) begin
                if (hold == 0) begin
                    snap_d = m_data; snap_i = blk_idx;
                    chk("bp_blk_idx", blk_idx, 5'(bp_beat * PL));
                end else begin
                    chk("bp_m_data_stable", m_data, snap_d);
                    chk("bp_blk_idx_stable", blk_idx, snap_i);
                end
                chk("bp_s_ready", s_ready, 1'b0);
                hold++;
            end
            if (frame_done) done = 1;
            cyc++;
            if (cyc > 4000) begin
                errors++;
                $display("FAIL frame_timeout: got no frame_done after %0d cycles", cyc);
                done = 1;
            end
            @(posedge CLK); #1;
            if (acc_in) widx++;
            if (acc_out) beat++;
            if (abort_after > 0 && widx == abort_after) begin
                rst_n = 0; s_valid = 0; m_ready = 0;
                #1;
                check_reset_vals();
                repeat (3) @(posedge CLK);
                #1 rst_n = 1;
                return;
            end
            start   = (mode == 0 && widx > 0 && widx < 5 && $urandom_range(0, 3) == 0);
            req_z   = 3'($urandom);
            s_valid = (mode != 0) || ($urandom_range(0, 3) != 0);
            s_data  = gen_word(mode, widx);
            m_ready = (beat == bp_beat && hold < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        start = 0; s_valid = 0; m_ready = 0;
    endtask

    initial begin
        rst_n = 0; start = 0; req_z = 0; s_data = 0; s_valid = 0; m_ready = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals();
        rst_n = 1;

        run_frame(3'b001, 1, -1, 0);
        chk("ones_words", last_words, 68);
        run_frame(3'b001, 2, -1, 0);
        run_frame(3'b100, 0, -1, 0);
        chk("z81_words", last_words, 203);
        repeat (3) begin
            @(negedge CLK);
            chk("post_frame_s_ready", s_ready, 1'b0);
        end
        run_frame(3'b010, 0, 3, 0);

        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            start = 1; req_z = (k == 0) ? 3'b011 : 3'b000;
            @(posedge CLK); #1;
            start = 0;
            @(negedge CLK);
            chk("cfg_err_pulse", cfg_err, 1'b1);
            chk("cfg_err_s_ready", s_ready, 1'b0);
            @(negedge CLK);
            chk("cfg_err_clear", cfg_err, 1'b0);
            chk("cfg_err_idle", s_ready, 1'b0);
        end

        run_frame(3'b001, 0, -1, 10);
        run_frame(3'b001, 2, -1, 0);

        for (int k = 0; k < 4; k++) run_frame(3'b001 << $urandom_range(0, 2), 0, -1, 0);

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
